// File: rtl/mips_cpu_pkg.sv
// ---------------------------------------------------------------------------
// mips_cpu_pkg
// Shared definitions for the MIPS memory arbiter slice.
//   WORD_W      : address/data width (fixed at 32)
//   arb_state_t : arbiter sequencer states
// ---------------------------------------------------------------------------
package mips_cpu_pkg;

    localparam int WORD_W = 32;

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        DATA   = 2'd1,
        COMMIT = 2'd2,
        HALT   = 2'd3
    } arb_state_t;

endpackage : mips_cpu_pkg

// File: rtl/mips_cpu_mem_arbiter_if.sv
// ---------------------------------------------------------------------------
// mips_cpu_mem_arbiter_if
// Bundles the core-side (instruction/data ports, clock enable) and the
// memory-side (shared single port with waitrequest) signals of the arbiter.
//   master : arbiter view (drives clock enable, held read data, memory bus)
//   slave  : environment view (core + memory drive requests and responses)
// ---------------------------------------------------------------------------
interface mips_cpu_mem_arbiter_if;
    import mips_cpu_pkg::*;

    // core side
    logic              cpu_active;
    logic              cpu_clk_enable;
    logic [WORD_W-1:0] instr_address;
    logic [WORD_W-1:0] instr_readdata;
    logic [WORD_W-1:0] data_address;
    logic              data_read;
    logic              data_write;
    logic [WORD_W-1:0] data_writedata;
    logic [WORD_W-1:0] data_readdata;

    // memory side
    logic [WORD_W-1:0] mem_address;
    logic              mem_read;
    logic              mem_write;
    logic [WORD_W-1:0] mem_writedata;
    logic [WORD_W-1:0] mem_readdata;
    logic              mem_waitrequest;

    modport master (
        input  cpu_active, instr_address, data_address, data_read, data_write,
               data_writedata, mem_readdata, mem_waitrequest,
        output cpu_clk_enable, instr_readdata, data_readdata, mem_address,
               mem_read, mem_write, mem_writedata
    );

    modport slave (
        output cpu_active, instr_address, data_address, data_read, data_write,
               data_writedata, mem_readdata, mem_waitrequest,
        input  cpu_clk_enable, instr_readdata, data_readdata, mem_address,
               mem_read, mem_write, mem_writedata
    );

endinterface : mips_cpu_mem_arbiter_if

// File: rtl/mips_cpu_ibuf.sv
// ---------------------------------------------------------------------------
// mips_cpu_ibuf
// One-entry instruction buffer (tag + valid + data). Lets the arbiter skip
// the memory fetch when the core re-executes the same PC. Only instantiated
// when MEM_ARB_IBUF_EN is defined.
//   clk, reset     : clock, asynchronous active-low reset
//   lookup_addr_i  : current PC, compared against the stored tag
//   fill_i         : accepted fetch; capture fill_addr_i / fill_data_i
//   wr_i, wr_addr_i: data-phase store; a store to the tagged PC invalidates
//   hit_o, data_o  : lookup result and buffered instruction word
// ---------------------------------------------------------------------------
module mips_cpu_ibuf
    import mips_cpu_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [WORD_W-1:0] lookup_addr_i,
    input  logic              fill_i,
    input  logic [WORD_W-1:0] fill_addr_i,
    input  logic [WORD_W-1:0] fill_data_i,
    input  logic              wr_i,
    input  logic [WORD_W-1:0] wr_addr_i,
    output logic              hit_o,
    output logic [WORD_W-1:0] data_o
);

    logic              valid_q;
    logic [WORD_W-1:0] tag_q;
    logic [WORD_W-1:0] data_q;

    // NOTE: sequential state is assigned with <= only, so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q <= 1'b0;
            tag_q   <= '0;
            data_q  <= '0;
        end else if (fill_i) begin
            valid_q <= 1'b1;
            tag_q   <= fill_addr_i;
            data_q  <= fill_data_i;
        end else if (wr_i && (wr_addr_i == tag_q)) begin
            // Self-modifying store: the buffered word is stale.
            valid_q <= 1'b0;
        end
    end

    assign hit_o  = valid_q && (tag_q == lookup_addr_i);
    assign data_o = data_q;

endmodule : mips_cpu_ibuf

// File: rtl/mips_cpu_mem_arbiter.sv
// ---------------------------------------------------------------------------
// mips_cpu_mem_arbiter
// Runs the Harvard MIPS core against one shared memory port with wait
// states. Each instruction is sequenced FETCH -> DATA -> COMMIT: the
// instruction is fetched into a holding register, the decoded load/store (if
// any) is performed, then the core's clock enable pulses for one cycle.
// A halted core (cpu_active low at COMMIT) parks the sequencer in HALT until
// reset.
//
// Ports:
//   clk           : system clock, rising edge
//   reset         : asynchronous active-low reset
//   bus (master)  : core instruction/data ports and the shared memory bus
//   retired_count : instructions committed since reset (wraps)
//   proto_err     : sticky, load and store requested together
//
// Configuration:
//   MEM_ARB_IBUF_EN : when defined, a one-entry instruction buffer skips the
//                     memory fetch for a repeated PC (invalidated by a store
//                     to that PC). Undefined: every fetch goes to memory.
// ---------------------------------------------------------------------------
module mips_cpu_mem_arbiter
    import mips_cpu_pkg::*;
(
    input  logic                    clk,
    input  logic                    reset,
    mips_cpu_mem_arbiter_if.master  bus,
    output logic [WORD_W-1:0]       retired_count,
    output logic                    proto_err
);

    arb_state_t        state_q, state_d;
    logic [WORD_W-1:0] instr_q, instr_d;
    logic [WORD_W-1:0] rdata_q, rdata_d;
    logic [WORD_W-1:0] retired_q, retired_d;
    logic              proto_q, proto_d;
    logic              cke_q;

    // combinational memory request for the current state
    logic              req_read, req_write;
    logic [WORD_W-1:0] req_addr, req_wdata;

    logic              ibuf_hit;
    logic [WORD_W-1:0] ibuf_data;

`ifdef MEM_ARB_IBUF_EN
    logic ibuf_fill;

    assign ibuf_fill = (state_q == FETCH) && !ibuf_hit && !bus.mem_waitrequest;

    mips_cpu_ibuf u_ibuf (
        .clk           (clk),
        .reset         (reset),
        .lookup_addr_i (bus.instr_address),
        .fill_i        (ibuf_fill),
        .fill_addr_i   (bus.instr_address),
        .fill_data_i   (bus.mem_readdata),
        .wr_i          (req_write && (state_q == DATA)),
        .wr_addr_i     (bus.data_address),
        .hit_o         (ibuf_hit),
        .data_o        (ibuf_data)
    );
`else
    assign ibuf_hit  = 1'b0;
    assign ibuf_data = '0;
`endif

    // Request and outputs depend only on state and the core's request lines;
    // the core is frozen until the commit pulse, so everything stays stable
    // for as long as waitrequest holds the access off.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path can
        // leave one unassigned and infer a latch.
        state_d   = state_q;
        instr_d   = instr_q;
        rdata_d   = rdata_q;
        proto_d   = proto_q;
        req_read  = 1'b0;
        req_write = 1'b0;
        req_addr  = '0;
        req_wdata = '0;

        case (state_q)
            FETCH: begin
                if (ibuf_hit) begin
                    instr_d = ibuf_data;
                    state_d = DATA;
                end else begin
                    req_read = 1'b1;
                    req_addr = bus.instr_address;
                    if (!bus.mem_waitrequest) begin
                        instr_d = bus.mem_readdata;
                        state_d = DATA;
                    end
                end
            end

            DATA: begin
                if (bus.data_write) begin
                    // A simultaneous load request is ignored; the store wins.
                    req_write = 1'b1;
                    req_addr  = bus.data_address;
                    req_wdata = bus.data_writedata;
                    if (bus.data_read) proto_d = 1'b1;
                    if (!bus.mem_waitrequest) state_d = COMMIT;
                end else if (bus.data_read) begin
                    req_read = 1'b1;
                    req_addr = bus.data_address;
                    if (!bus.mem_waitrequest) begin
                        rdata_d = bus.mem_readdata;
                        state_d = COMMIT;
                    end
                end else begin
                    state_d = COMMIT;
                end
            end

            COMMIT: state_d = bus.cpu_active ? FETCH : HALT;

            HALT:   state_d = HALT;

            default: state_d = FETCH;
        endcase
    end

    assign retired_d = (state_q == COMMIT) ? retired_q + 1'b1 : retired_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= FETCH;
            instr_q   <= '0;
            rdata_q   <= '0;
            retired_q <= '0;
            proto_q   <= 1'b0;
            cke_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            instr_q   <= instr_d;
            rdata_q   <= rdata_d;
            retired_q <= retired_d;
            proto_q   <= proto_d;
            // Registered so the core's enable is a clean flop output that is
            // high exactly during the COMMIT cycle.
            cke_q     <= (state_d == COMMIT);
        end
    end

    // The state register resets to FETCH, whose request is a read; gating
    // with reset keeps the bus idle while reset is held and drops any
    // in-flight strobe the moment reset asserts.
    assign bus.mem_read      = req_read  & reset;
    assign bus.mem_write     = req_write & reset;
    assign bus.mem_address   = reset ? req_addr  : '0;
    assign bus.mem_writedata = reset ? req_wdata : '0;

    assign bus.cpu_clk_enable = cke_q;
    assign bus.instr_readdata = instr_q;
    assign bus.data_readdata  = rdata_q;
    assign retired_count      = retired_q;
    assign proto_err          = proto_q;

endmodule : mips_cpu_mem_arbiter

// File: tb/tb_mips_cpu_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mips_cpu_mem_arbiter
// Directed bench for mips_cpu_mem_arbiter. The bench plays both the core and
// the memory by driving the interface directly, cycle by cycle, and checks
// the arbiter's outputs one time unit after each rising edge.
// ---------------------------------------------------------------------------
module tb_mips_cpu_mem_arbiter;
    import mips_cpu_pkg::*;

    logic              clk;
    logic              reset;
    logic [WORD_W-1:0] retired_count;
    logic              proto_err;

    int n_cmp = 0;
    int n_err = 0;

    mips_cpu_mem_arbiter_if bus ();

    mips_cpu_mem_arbiter dut (
        .clk           (clk),
        .reset         (reset),
        .bus           (bus.master),
        .retired_count (retired_count),
        .proto_err     (proto_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

`ifdef MEM_ARB_IBUF_EN
    localparam logic IBUF = 1'b1;
`else
    localparam logic IBUF = 1'b0;
`endif

    initial begin
        reset               = 1'b0;
        bus.cpu_active      = 1'b1;
        bus.instr_address   = 32'hBFC0_0000;
        bus.data_address    = '0;
        bus.data_read       = 1'b0;
        bus.data_write      = 1'b0;
        bus.data_writedata  = '0;
        bus.mem_readdata    = 32'h2408_0005;   // addiu $t0,$zero,5
        bus.mem_waitrequest = 1'b0;
        #1;

        // ---- reset values ----
        chk("rst_mem_read",  {31'd0, bus.mem_read},       32'd0);
        chk("rst_mem_write", {31'd0, bus.mem_write},      32'd0);
        chk("rst_mem_addr",  bus.mem_address,             32'd0);
        chk("rst_mem_wdata", bus.mem_writedata,           32'd0);
        chk("rst_cke",       {31'd0, bus.cpu_clk_enable}, 32'd0);
        chk("rst_instr",     bus.instr_readdata,          32'd0);
        chk("rst_rdata",     bus.data_readdata,           32'd0);
        chk("rst_retired",   retired_count,               32'd0);
        chk("rst_proto",     {31'd0, proto_err},          32'd0);

        // ---- ADDIU, zero-wait: fetch c1, data c2, commit c3 ----
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("addiu_c1_read", {31'd0, bus.mem_read},       32'd1);
        chk("addiu_c1_addr", bus.mem_address,             32'hBFC0_0000);
        chk("addiu_c1_cke",  {31'd0, bus.cpu_clk_enable}, 32'd0);
        tick();
        chk("addiu_c2_instr", bus.instr_readdata,                      32'h2408_0005);
        chk("addiu_c2_idle",  {30'd0, bus.mem_read, bus.mem_write},    32'd0);
        chk("addiu_c2_cke",   {31'd0, bus.cpu_clk_enable},             32'd0);
        tick();
        chk("addiu_c3_cke",  {31'd0, bus.cpu_clk_enable}, 32'd1);
        chk("addiu_c3_ret",  retired_count,               32'd0);

        // ---- LW with two wait cycles in DATA ----
        tick();
        bus.instr_address = 32'hBFC0_0004;
        bus.mem_readdata  = 32'h8C09_2000;     // lw $t1,0x2000($zero)
        #1;
        chk("lw_c1_cke",  {31'd0, bus.cpu_clk_enable}, 32'd0);
        chk("lw_c1_ret",  retired_count,               32'd1);
        chk("lw_c1_addr", bus.mem_address,             32'hBFC0_0004);
        tick();
        bus.data_read       = 1'b1;
        bus.data_address    = 32'h0000_2000;
        bus.mem_waitrequest = 1'b1;
        bus.mem_readdata    = 32'hDEAD_BEEF;
        #1;
        chk("lw_c2_instr", bus.instr_readdata,        32'h8C09_2000);
        chk("lw_c2_read",  {31'd0, bus.mem_read},     32'd1);
        chk("lw_c2_addr",  bus.mem_address,           32'h0000_2000);
        chk("lw_c2_rdata", bus.data_readdata,         32'd0);
        tick();
        chk("lw_c3_addr",  bus.mem_address,           32'h0000_2000);
        chk("lw_c3_read",  {31'd0, bus.mem_read},     32'd1);
        chk("lw_c3_rdata", bus.data_readdata,         32'd0);
        chk("lw_c3_cke",   {31'd0, bus.cpu_clk_enable}, 32'd0);
        tick();
        bus.mem_waitrequest = 1'b0;
        bus.mem_readdata    = 32'hCAFE_F00D;
        #1;
        chk("lw_c4_addr",  bus.mem_address,           32'h0000_2000);
        chk("lw_c4_read",  {31'd0, bus.mem_read},     32'd1);
        tick();
        bus.data_read = 1'b0;
        #1;
        chk("lw_c5_cke",   {31'd0, bus.cpu_clk_enable}, 32'd1);
        chk("lw_c5_rdata", bus.data_readdata,           32'hCAFE_F00D);
        chk("lw_c5_read",  {31'd0, bus.mem_read},       32'd0);

        // ---- SW 0x12345678 to 0x1000 ----
        tick();
        bus.instr_address = 32'hBFC0_0008;
        bus.mem_readdata  = 32'hAC0A_1000;     // sw $t2,0x1000($zero)
        #1;
        chk("sw_c1_ret",  retired_count,           32'd2);
        chk("sw_c1_read", {31'd0, bus.mem_read},   32'd1);
        tick();
        bus.data_write     = 1'b1;
        bus.data_address   = 32'h0000_1000;
        bus.data_writedata = 32'h1234_5678;
        #1;
        chk("sw_c2_write", {31'd0, bus.mem_write}, 32'd1);
        chk("sw_c2_read",  {31'd0, bus.mem_read},  32'd0);
        chk("sw_c2_addr",  bus.mem_address,        32'h0000_1000);
        chk("sw_c2_wdata", bus.mem_writedata,      32'h1234_5678);
        tick();
        bus.data_write = 1'b0;
        #1;
        chk("sw_c3_write", {31'd0, bus.mem_write},       32'd0);
        chk("sw_c3_wdata", bus.mem_writedata,            32'd0);
        chk("sw_c3_cke",   {31'd0, bus.cpu_clk_enable},  32'd1);
        chk("sw_c3_proto", {31'd0, proto_err},           32'd0);

        // ---- load and store requested together ----
        tick();
        bus.instr_address = 32'hBFC0_000C;
        bus.mem_readdata  = 32'h0085_1025;
        #1;
        chk("both_c1_ret", retired_count, 32'd3);
        tick();
        bus.data_read      = 1'b1;
        bus.data_write     = 1'b1;
        bus.data_address   = 32'h0000_3000;
        bus.data_writedata = 32'hA5A5_A5A5;
        #1;
        chk("both_c2_write", {31'd0, bus.mem_write}, 32'd1);
        chk("both_c2_read",  {31'd0, bus.mem_read},  32'd0);
        chk("both_c2_wdata", bus.mem_writedata,      32'hA5A5_A5A5);
        tick();
        bus.data_read  = 1'b0;
        bus.data_write = 1'b0;
        #1;
        chk("both_c3_proto", {31'd0, proto_err},          32'd1);
        chk("both_c3_cke",   {31'd0, bus.cpu_clk_enable}, 32'd1);

        // ---- repeat same PC: buffered when the ibuf is built in ----
        tick();
        bus.mem_readdata = 32'h1111_1111;
        #1;
        chk("loop1_ret",   retired_count,          32'd4);
        chk("loop1_proto", {31'd0, proto_err},     32'd1);
        chk("loop1_read",  {31'd0, bus.mem_read},  IBUF ? 32'd0 : 32'd1);
        tick();
        bus.data_write     = 1'b1;                 // store to the looping PC
        bus.data_address   = 32'hBFC0_000C;
        bus.data_writedata = 32'h0000_0000;
        #1;
        chk("loop1_instr", bus.instr_readdata,     IBUF ? 32'h0085_1025 : 32'h1111_1111);
        chk("loop1_write", {31'd0, bus.mem_write}, 32'd1);
        tick();
        bus.data_write = 1'b0;
        #1;
        chk("loop1_cke", {31'd0, bus.cpu_clk_enable}, 32'd1);
        tick();
        bus.mem_readdata = 32'h2222_2222;
        #1;
        chk("loop2_ret",  retired_count,         32'd5);
        chk("loop2_read", {31'd0, bus.mem_read}, 32'd1);
        chk("loop2_addr", bus.mem_address,       32'hBFC0_000C);
        tick();
        chk("loop2_instr", bus.instr_readdata, 32'h2222_2222);
        tick();

        // ---- reset asserted mid-fetch while waitrequest is high ----
        tick();
        bus.instr_address   = 32'hBFC0_0010;
        bus.mem_waitrequest = 1'b1;
        #1;
        chk("rstmid_ret",   retired_count,         32'd6);
        chk("rstmid_read",  {31'd0, bus.mem_read}, 32'd1);
        tick();
        chk("rstmid_hold",  {31'd0, bus.mem_read}, 32'd1);
        chk("rstmid_haddr", bus.mem_address,       32'hBFC0_0010);
        #2;
        reset = 1'b0;
        #1;
        chk("rstmid_drop",   {31'd0, bus.mem_read}, 32'd0);
        chk("rstmid_addr0",  bus.mem_address,       32'd0);
        chk("rstmid_ret0",   retired_count,         32'd0);
        chk("rstmid_proto0", {31'd0, proto_err},    32'd0);
        chk("rstmid_instr0", bus.instr_readdata,    32'd0);
        chk("rstmid_rdata0", bus.data_readdata,     32'd0);

        // ---- halt: cpu_active low at COMMIT ----
        @(negedge clk);
        reset               = 1'b1;
        bus.instr_address   = 32'hBFC0_0000;
        bus.mem_waitrequest = 1'b0;
        bus.mem_readdata    = 32'h0000_000D;       // break
        #1;
        chk("halt_c1_read", {31'd0, bus.mem_read}, 32'd1);
        tick();
        tick();
        bus.cpu_active = 1'b0;
        #1;
        chk("halt_c3_cke", {31'd0, bus.cpu_clk_enable}, 32'd1);
        tick();
        bus.cpu_active = 1'b1;                     // must not wake a halted arbiter
        bus.data_read  = 1'b1;
        #1;
        chk("halt_ret", retired_count, 32'd1);
        for (int i = 0; i < 20; i++) begin
            chk("halt_idle", {29'd0, bus.mem_read, bus.mem_write, bus.cpu_clk_enable}, 32'd0);
            tick();
        end
        chk("halt_ret_end", retired_count, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_mips_cpu_mem_arbiter

// File: doc/mips_cpu_mem_arbiter.md
# mips_cpu_mem_arbiter

Sequencer and arbiter that lets the Harvard MIPS core run against a single shared memory port with wait states. Each instruction is split into fetch, data and commit phases: the block fetches the instruction into a holding register, then performs any load or store the decoded instruction requests, then pulses the core's clock enable for exactly one cycle so that PC, register file and HI/LO advance. It sits between the core's instruction/data ports and the memory bus.

## Interface
Parameters:
- none (address/data widths fixed at 32)

Ports:
- clk  in  1  single system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- cpu_active  in  1  core's active output; low = core halted
- cpu_clk_enable  out  1  one-cycle commit strobe to core
- instr_address  in  32  core PC
- instr_readdata  out  32  held instruction word to core
- data_address  in  32  core data address
- data_read  in  1  core load request
- data_write  in  1  core store request
- data_writedata  in  32  core store data
- data_readdata  out  32  held load data to core
- mem_address  out  32  shared memory address
- mem_read  out  1  memory read strobe
- mem_write  out  1  memory write strobe
- mem_writedata  out  32  memory write data
- mem_readdata  in  32  memory read data
- mem_waitrequest  in  1  high = current access not yet accepted
- retired_count  out  32  instructions committed since reset
- proto_err  out  1  sticky: data_read and data_write seen together

## Operation
- States: FETCH, DATA, COMMIT, HALT. Reset state FETCH.
- FETCH: mem_address=instr_address, mem_read=1. When mem_waitrequest=0, latch mem_readdata into instr_readdata; next state DATA.
- DATA: decode visible through core. If data_write: mem_write=1, mem_address=data_address, mem_writedata=data_writedata. Else if data_read: mem_read=1, latch mem_readdata into data_readdata on acceptance. Else no access. Leave for COMMIT when access accepted or none needed.
- Both data_read and data_write high: perform write only, set proto_err (cleared only by reset).
- COMMIT: cpu_clk_enable=1 for this cycle only; retired_count+=1 (wraps 0xFFFFFFFF->0); next FETCH, or HALT if cpu_active=0.
- HALT: no memory strobes, cpu_clk_enable=0; leave only via reset.
- While mem_waitrequest=1, mem_address, mem_read, mem_write, mem_writedata held stable.
- Outside FETCH/DATA accesses, mem_read=mem_write=0; mem_address/mem_writedata don't-care (drive 0).

## Timing
- Reset values: state FETCH, cpu_clk_enable 0, mem_read 0, mem_write 0, mem_address 0, mem_writedata 0, instr_readdata 0, data_readdata 0, retired_count 0, proto_err 0.
- Zero-wait memory: 3 cycles/instruction with data access, 3 without (DATA state lasts one cycle either way). Each waitrequest cycle adds one cycle.
- instr_readdata and data_readdata registered; change only on accepted read.
- cpu_clk_enable is registered from state (glitch-free); exactly one pulse per retired instruction.
- Reset asserted mid-access: all strobes drop asynchronously; any in-flight access abandoned; retired_count cleared.

## Configuration
- MEM_ARB_IBUF_EN defined: one-entry instruction buffer (tag+valid). In FETCH, if valid and tag==instr_address, no mem_read issued; instr_readdata kept; FETCH→DATA in one cycle. Any DATA-state write whose address equals tag clears valid. Reset clears valid.
- Undefined: every instruction fetched from memory; no tag storage.

## Structure
- Shared package mips_cpu_pkg: arb_state_t enum (FETCH, DATA, COMMIT, HALT), WORD_W=32 constant.
- Sub-module mips_cpu_ibuf (tag, valid, data register, hit/invalidate logic), instantiated only under MEM_ARB_IBUF_EN.

## Test plan
- Zero-wait memory, instruction ADDIU at 0xBFC00000: mem_read at 0xBFC00000 cycle 1, cpu_clk_enable pulse cycle 3, retired_count=1.
- LW with waitrequest high 2 cycles in DATA: mem_address=data_address held 3 cycles, data_readdata updated on third, commit cycle 5.
- SW 0x12345678 to 0x1000: mem_write=1, mem_writedata=0x12345678 one cycle; no mem_read in DATA.
- data_read and data_write both high: only mem_write issued, proto_err=1 and stays 1 until reset.
- cpu_active low at COMMIT: state HALT, no further strobes over 20 cycles; reset mid-fetch with waitrequest high drops mem_read immediately, retired_count=0.
- With MEM_ARB_IBUF_EN, loop on same PC: second fetch issues no mem_read; store to that PC forces refetch next instruction.
